// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the radix-4 sqrt root-digit path:
// FSM states, per-format iteration/root sizes, and the one-hot digit type.
package fsqrt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } fsm_e;

    // Root widths include the 2-bit initial root plus 2 bits per digit.
    localparam int FP16_ITER_NUM = 6;
    localparam int FP16_ROOT_W   = 14;
    localparam int FP32_ITER_NUM = 13;
    localparam int FP32_ROOT_W   = 28;
    localparam int FP64_ITER_NUM = 27;
    localparam int FP64_ROOT_W   = 56;

    typedef logic [4:0] dig_t;

    localparam int DIG_N2 = 0;
    localparam int DIG_N1 = 1;
    localparam int DIG_Z0 = 2;
    localparam int DIG_P1 = 3;
    localparam int DIG_P2 = 4;

    localparam dig_t DIG_ZERO = 5'b00100;

    function automatic logic dig_onehot(input dig_t d);
        return (d != '0) && ((d & (d - 5'd1)) == '0);
    endfunction

endpackage

// File: rtl/fsqrt_r4_otfc_step.sv
// Combinational on-the-fly conversion of one radix-4 root digit into Q/QM.
// Pure AND-OR select so two copies can be chained for a two-digit/cycle variant.
module fsqrt_r4_otfc_step
    import fsqrt_pkg::*;
#(
    parameter int W = 56
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    input  dig_t         dig_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o
);

    logic [W-3:0] q_sh;
    logic [W-3:0] qm_sh;

    assign q_sh  = q_i[W-3:0];
    assign qm_sh = qm_i[W-3:0];

    // Non-negative digits extend Q, negative digits borrow from QM.
    assign q_o  = ({W{dig_i[DIG_P2]}} & {q_sh,  2'b10})
                | ({W{dig_i[DIG_P1]}} & {q_sh,  2'b01})
                | ({W{dig_i[DIG_Z0]}} & {q_sh,  2'b00})
                | ({W{dig_i[DIG_N1]}} & {qm_sh, 2'b11})
                | ({W{dig_i[DIG_N2]}} & {qm_sh, 2'b10});

    assign qm_o = ({W{dig_i[DIG_P2]}} & {q_sh,  2'b01})
                | ({W{dig_i[DIG_P1]}} & {q_sh,  2'b00})
                | ({W{dig_i[DIG_Z0]}} & {qm_sh, 2'b11})
                | ({W{dig_i[DIG_N1]}} & {qm_sh, 2'b10})
                | ({W{dig_i[DIG_N2]}} & {qm_sh, 2'b01});

endmodule

// File: rtl/fsqrt_r4_otfc.sv
// Radix-4 sqrt root-digit consumer: OTFC of Q/QM, final root/sticky select.
// Optional digit legality check enabled by FSQRT_R4_OTFC_DIG_CHK_EN.
module fsqrt_r4_otfc
    import fsqrt_pkg::*;
#(
    parameter int ROOT_W   = 56,
    parameter int ITER_NUM = 27,
    parameter int INIT_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid_i,
    output logic              start_ready_o,
    input  logic [INIT_W-1:0] init_root_i,
    input  logic              dig_valid_i,
    input  logic              dig_n2_i,
    input  logic              dig_n1_i,
    input  logic              dig_z0_i,
    input  logic              dig_p1_i,
    input  logic              dig_p2_i,
    input  logic              rem_valid_i,
    input  logic              rem_sign_i,
    input  logic              rem_nz_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [ROOT_W-1:0] root_o,
    output logic              sticky_o,
    output logic              dig_err_o
);

    localparam int CNT_W = $clog2(ITER_NUM + 1);

    fsm_e              state, state_nxt;
    logic [ROOT_W-1:0] q, qm, q_step, qm_step;
    logic [CNT_W-1:0]  cnt;
    logic [INIT_W-1:0] init_m1;
    dig_t              dig_raw, dig_use;
    logic              start_acc, dig_acc, last_dig, rem_acc, res_acc;

    assign dig_raw = {dig_p2_i, dig_p1_i, dig_z0_i, dig_n1_i, dig_n2_i};
    assign init_m1 = init_root_i - INIT_W'(1);

    assign start_ready_o = (state == ST_IDLE);
    assign start_acc     = (state == ST_IDLE) && start_valid_i;
    assign dig_acc       = (state == ST_ITER) && dig_valid_i;
    assign last_dig      = (cnt == CNT_W'(ITER_NUM - 1));
    assign rem_acc       = (state == ST_FIN)  && rem_valid_i;
    assign res_acc       = (state == ST_DONE) && res_ready_i;

`ifdef FSQRT_R4_OTFC_DIG_CHK_EN
    logic dig_bad;
    logic dig_err_q;

    assign dig_bad   = !dig_onehot(dig_raw);
    // An illegal vector is consumed as digit 0 so the op still completes.
    assign dig_use   = dig_bad ? DIG_ZERO : dig_raw;
    assign dig_err_o = dig_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dig_err_q <= 1'b0;
        else if (start_acc)
            dig_err_q <= 1'b0;
        else if (dig_acc && dig_bad)
            dig_err_q <= 1'b1;
    end
`else
    assign dig_use   = dig_raw;
    assign dig_err_o = 1'b0;
`endif

    fsqrt_r4_otfc_step #(
        .W (ROOT_W)
    ) u_step (
        .q_i   (q),
        .qm_i  (qm),
        .dig_i (dig_use),
        .q_o   (q_step),
        .qm_o  (qm_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_valid_i)              state_nxt = ST_ITER;
            ST_ITER: if (dig_valid_i && last_dig)    state_nxt = ST_FIN;
            ST_FIN:  if (rem_valid_i)                state_nxt = ST_DONE;
            ST_DONE: if (res_ready_i)                state_nxt = ST_IDLE;
            default:                                 state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q   <= '0;
            qm  <= '0;
            cnt <= '0;
        end else if (start_acc) begin
            q   <= ROOT_W'(init_root_i);
            qm  <= ROOT_W'(init_m1);
            cnt <= '0;
        end else if (dig_acc) begin
            q   <= q_step;
            qm  <= qm_step;
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Result registers only load in FIN, so they stay frozen through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            root_o      <= '0;
            sticky_o    <= 1'b0;
            res_valid_o <= 1'b0;
        end else if (rem_acc) begin
            root_o      <= rem_sign_i ? qm : q;
            sticky_o    <= rem_nz_i;
            res_valid_o <= 1'b1;
        end else if (res_acc) begin
            res_valid_o <= 1'b0;
        end
    end

endmodule
